onehot_decoder_pipe: RTL and testbench



---
 rtl/onehot_pkg.sv | 35 +++
 rtl/skid_buffer2.sv | 65 ++++++
 rtl/onehot_decoder_pipe.sv | 79 +++++++
 tb/tb_onehot_decoder_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared decode helpers for the pipelined one-hot decoder.
// Words are built at the widest size and sliced by the user.
package onehot_pkg;

  localparam int MAX_IN_W = 6;
  localparam int MAX_N    = 64;

  // Decoded word; out-of-range codes give the idle pattern.
  function automatic logic [MAX_N-1:0] onehot_f(
    input logic [MAX_IN_W-1:0] code,
    input int                  out_n,
    input bit                  active_low
  );
    logic [MAX_N-1:0] w;
    w = '0;
    if (int'(code) < out_n) w[code] = 1'b1;
    if (active_low) w = ~w;
    return w;
  endfunction

  function automatic logic [MAX_N-1:0] idle_pattern_f(
    input bit active_low
  );
    return active_low ? '1 : '0;
  endfunction

  function automatic bit cfg_ok_f(
    input int in_w,
    input int out_n
  );
    return (in_w >= 1) && (in_w <= MAX_IN_W) &&
           (out_n >= 2) && (out_n <= (1 << in_w));
  endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry skid buffer: main register drives the outputs,
// skid register absorbs one beat while downstream stalls.
module skid_buffer2 #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              main_vld_q, main_vld_d;
  logic [DATA_W-1:0] main_dat_q, main_dat_d;
  logic              skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0] skid_dat_q, skid_dat_d;
  logic              accept;
  logic              drain;

  assign in_ready  = !skid_vld_q;
  assign accept    = in_valid && !skid_vld_q;
  assign drain     = main_vld_q && out_ready;
  assign out_valid = main_vld_q;
  assign out_data  = main_dat_q;

  // Refill main from skid first, else from input; else park in skid.
  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (!main_vld_q || drain) begin
      if (skid_vld_q) begin
        main_vld_d = 1'b1;
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = accept;
        if (accept) main_dat_d = in_data;
      end
    end else if (accept) begin
      skid_vld_d = 1'b1;
      skid_dat_d = in_data;
    end
  end

  // Storage registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Pipelined binary to one-hot decoder with handshake,
// polarity select and saturating out-of-range counter.
module onehot_decoder_pipe
  import onehot_pkg::*;
#(
  parameter int IN_W       = 3,
  parameter int OUT_N      = 8,
  parameter int ACTIVE_LOW = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_N-1:0]     out_q,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (!cfg_ok_f(IN_W, OUT_N)) begin : g_cfg_err
    $error("onehot_decoder_pipe: bad IN_W/OUT_N");
  end

  localparam logic [MAX_N-1:0] IDLE_W =
    idle_pattern_f(ACTIVE_LOW != 0);
  localparam logic [OUT_N-1:0] IDLE = IDLE_W[OUT_N-1:0];

  logic [MAX_N-1:0]     dec_w;
  logic                 in_err;
  logic [OUT_N:0]       buf_dat;
  logic                 buf_vld;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  wire                  unused_dec = ^dec_w;

  assign dec_w = onehot_f(MAX_IN_W'(in_code), OUT_N,
                          ACTIVE_LOW != 0);

  if (OUT_N == (1 << IN_W)) begin : g_full
    assign in_err = 1'b0;
  end else begin : g_part
    assign in_err =
      {1'b0, in_code} >= (IN_W + 1)'(OUT_N);
  end

  skid_buffer2 #(
    .DATA_W (OUT_N + 1)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_err, dec_w[OUT_N-1:0]}),
    .out_valid (buf_vld),
    .out_ready (out_ready),
    .out_data  (buf_dat)
  );

  assign out_valid = buf_vld;
  assign out_q     = buf_vld ? buf_dat[OUT_N-1:0] : IDLE;
  assign out_err   = buf_vld && buf_dat[OUT_N];
  assign err_cnt   = err_cnt_q;

  // Count accepted out-of-range codes, holding at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_valid && in_ready && in_err && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: three configurations share
// one stimulus stream and are checked against a queue model.
module tb_onehot_decoder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       iv;
  logic [2:0] code;
  logic       ordy;

  logic       rdy0, rdy1, rdy2;
  logic       v0, v1, v2;
  logic [7:0] q0, q2;
  logic [5:0] q1;
  logic       e0, e1, e2;
  logic [7:0] c0, c1, c2;

  onehot_decoder_pipe #(
    .IN_W(3), .OUT_N(8), .ACTIVE_LOW(0), .ERR_CNT_W(8)
  ) u_d0 (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy0),
    .in_code(code), .out_valid(v0), .out_ready(ordy),
    .out_q(q0), .out_err(e0), .err_cnt(c0)
  );

  onehot_decoder_pipe #(
    .IN_W(3), .OUT_N(6), .ACTIVE_LOW(0), .ERR_CNT_W(8)
  ) u_d1 (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy1),
    .in_code(code), .out_valid(v1), .out_ready(ordy),
    .out_q(q1), .out_err(e1), .err_cnt(c1)
  );

  onehot_decoder_pipe #(
    .IN_W(3), .OUT_N(8), .ACTIVE_LOW(1), .ERR_CNT_W(8)
  ) u_d2 (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(rdy2),
    .in_code(code), .out_valid(v2), .out_ready(ordy),
    .out_q(q2), .out_err(e2), .err_cnt(c2)
  );

  int aq[3], av[3], ae[3], ac[3], ar[3];
  always_comb begin
    aq[0] = int'(q0); aq[1] = int'(q1); aq[2] = int'(q2);
    av[0] = int'(v0); av[1] = int'(v1); av[2] = int'(v2);
    ae[0] = int'(e0); ae[1] = int'(e1); ae[2] = int'(e2);
    ac[0] = int'(c0); ac[1] = int'(c1); ac[2] = int'(c2);
    ar[0] = int'(rdy0); ar[1] = int'(rdy1); ar[2] = int'(rdy2);
  end

  int pass_cnt = 0;
  int tot_cnt  = 0;

  int mq[$];
  int ec[3];
  int nn[3] = '{8, 6, 8};
  bit al[3] = '{1'b0, 1'b0, 1'b1};

  typedef struct {
    bit v;
    int c;
    bit r;
    int ev;
    int eq;
    int erdy;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(string nm, int act, int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h",
                  nm, act, exp);
  endtask

  function automatic int mask_f(int n);
    return (1 << n) - 1;
  endfunction

  function automatic int dec_f(int c, int n, bit a);
    int w;
    w = (c < n) ? (1 << c) : 0;
    if (a) w = ~w & mask_f(n);
    return w;
  endfunction

  task automatic check_all();
    int eq, ee, ev;
    for (int d = 0; d < 3; d++) begin
      ev = (mq.size() > 0) ? 1 : 0;
      if (ev != 0) begin
        eq = dec_f(mq[0], nn[d], al[d]);
        ee = (mq[0] >= nn[d]) ? 1 : 0;
      end else begin
        eq = al[d] ? mask_f(nn[d]) : 0;
        ee = 0;
      end
      chk($sformatf("d%0d out_valid", d), av[d], ev);
      chk($sformatf("d%0d out_q", d), aq[d], eq);
      chk($sformatf("d%0d out_err", d), ae[d], ee);
      chk($sformatf("d%0d err_cnt", d), ac[d], ec[d]);
      chk($sformatf("d%0d in_ready", d), ar[d],
          (mq.size() < 2) ? 1 : 0);
    end
  endtask

  task automatic cycle(bit v, int c, bit r, bit rs);
    bit acc, drn;
    rst  = rs;
    iv   = v;
    code = c[2:0];
    ordy = r;
    acc  = !rs && v && (mq.size() < 2);
    drn  = (mq.size() > 0) && r;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      for (int d = 0; d < 3; d++) ec[d] = 0;
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(c);
        for (int d = 0; d < 3; d++)
          if (c >= nn[d] && ec[d] < 255) ec[d]++;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; iv = 1'b0; code = '0; ordy = 1'b0;
    for (int d = 0; d < 3; d++) ec[d] = 0;

    tbl[0]  = '{1, 5, 1, 1, 'h20, 1};
    for (int i = 0; i < 8; i++)
      tbl[1+i] = '{1, i, 1, 1, 1 << i, 1};
    tbl[9]  = '{0, 0, 1, 0, 'h00, 1};
    tbl[10] = '{1, 2, 0, 1, 'h04, 1};
    tbl[11] = '{1, 6, 0, 1, 'h04, 0};
    tbl[12] = '{1, 3, 0, 1, 'h04, 0};
    tbl[13] = '{0, 0, 1, 1, 'h40, 1};
    tbl[14] = '{0, 0, 1, 0, 'h00, 1};

    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("reset d0 out_valid", av[0], 0);
    chk("reset d2 idle", aq[2], 'hFF);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].v, tbl[i].c, tbl[i].r, 0);
      chk($sformatf("tbl%0d valid", i), av[0], tbl[i].ev);
      chk($sformatf("tbl%0d q", i), aq[0], tbl[i].eq);
      chk($sformatf("tbl%0d rdy", i), ar[0], tbl[i].erdy);
    end

    cycle(0, 0, 1, 1);
    cycle(1, 7, 1, 0);
    chk("sat first cnt", ac[1], 1);
    chk("sat first err", ae[1], 1);
    chk("sat first q", aq[1], 0);
    for (int i = 0; i < 299; i++) cycle(1, 7, 1, 0);
    chk("sat cnt 255", ac[1], 255);
    cycle(1, 6, 1, 0);
    chk("sat no wrap", ac[1], 255);
    chk("full range cnt", ac[0], 0);
    chk("full range err", ae[0], 0);

    cycle(0, 0, 1, 1);
    chk("al idle", aq[2], 'hFF);
    cycle(1, 0, 1, 0);
    chk("al code0", aq[2], 'hFE);

    cycle(1, 1, 0, 0);
    cycle(1, 7, 0, 0);
    chk("full rdy", ar[0], 0);
    cycle(1, 4, 0, 1);
    chk("rst mid valid", av[0], 0);
    chk("rst mid q", aq[0], 0);
    chk("rst mid rdy", ar[0], 1);
    chk("rst mid cnt", ac[1], 0);
    chk("rst mid al q", aq[2], 'hFF);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0);
      chk($sformatf("no stale %0d", i), av[0], 0);
    end

    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7),
            $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
